// File: rtl/spi_word_target_if.sv
// SPI bus between the M0 master and a word target.
// The target takes the slave modport; a master or bench takes the master modport.
interface spi_word_target_if;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_cs_n, output spi_clk, output spi_mosi, input spi_miso);
    modport slave  (input spi_cs_n, input spi_clk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_word_target.sv
// SPI memory target for 40-bit word frames: 8-bit command, then 16-bit address and
// 16-bit data, both LSB-first. The internal word array also has a backdoor preload port.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | CS high, or first cycle after CS falls
// CMD     | shifting the command byte in, MSB-first (rises 1-8)
// ADDR_RD | shifting the read address in, LSB-first (rises 9-24)
// ADDR_WR | shifting the write address in, LSB-first (rises 9-24)
// DATA_RD | shifting the read word out on MISO at each SPI clock fall
// DATA_WR | shifting the write word in (rises 25-40), committed at rise 40
// DEAD    | unknown command; all edges ignored until CS is released
module spi_word_target #(
    parameter int AW        = 8,
    parameter bit READ_ONLY = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    spi_word_target_if.slave    spi,
    input  logic                load_en,
    input  logic [AW-1:0]       load_addr,
    input  logic [15:0]         load_data,
    output logic                busy,
    output logic                cmd_err
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_RD, ADDR_WR, DATA_RD, DATA_WR, DEAD
    } state_t;

    state_t        state;
    logic          sclk_prev;
    logic [5:0]    bit_cnt;
    logic [6:0]    cmd;
    logic [AW-1:0] addr;
    logic [14:0]   wbuf;
    logic [15:0]   shreg;
    logic [15:0]   mem [0:(1<<AW)-1];

    logic          rise;
    logic          fall;
    logic          commit;
    logic [7:0]    cmd_next;
    logic [5:0]    addr_pos;
    logic [AW-1:0] addr_next;
    logic [15:0]   wdata_next;

    assign rise       = spi.spi_clk & ~sclk_prev;
    assign fall       = ~spi.spi_clk & sclk_prev;
    assign cmd_next   = {cmd, spi.spi_mosi};
    assign wdata_next = {spi.spi_mosi, wbuf};

    // Address bits at or above AW shift out to zero, which gives the aliasing for free.
    assign addr_pos   = bit_cnt - 6'd8;
    assign addr_next  = addr | (AW'(spi.spi_mosi) << addr_pos);

    assign commit = ~rst & ~spi.spi_cs_n & rise & (state == DATA_WR)
                  & (bit_cnt == 6'd39) & ~READ_ONLY;

    assign busy = ~spi.spi_cs_n & (bit_cnt != 6'd0);

    // An SPI commit takes the write port over a coincident backdoor load.
    always_ff @(posedge clk) begin
        if (commit)
            mem[addr] <= wdata_next;
        else if (load_en)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 6'd0;
            sclk_prev    <= 1'b0;
            cmd_err      <= 1'b0;
            spi.spi_miso <= 1'b0;
        end else begin
            sclk_prev <= spi.spi_clk;
            cmd_err   <= 1'b0;
            if (spi.spi_cs_n) begin
                state        <= IDLE;
                bit_cnt      <= 6'd0;
                spi.spi_miso <= 1'b0;
            end else begin
                if (rise && bit_cnt != 6'd40)
                    bit_cnt <= bit_cnt + 6'd1;
                case (state)
                    IDLE, CMD: begin
                        state        <= CMD;
                        spi.spi_miso <= 1'b0;
                        if (rise) begin
                            cmd <= cmd_next[6:0];
                            if (bit_cnt == 6'd7) begin
                                addr <= '0;
                                if (cmd_next == 8'h03)
                                    state <= ADDR_RD;
                                else if (cmd_next == 8'h02)
                                    state <= ADDR_WR;
                                else begin
                                    state   <= DEAD;
                                    cmd_err <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR_RD, ADDR_WR: begin
                        spi.spi_miso <= 1'b0;
                        if (rise) begin
                            addr <= addr_next;
                            if (bit_cnt == 6'd23) begin
                                if (state == ADDR_RD) begin
                                    shreg <= mem[addr_next];
                                    state <= DATA_RD;
                                end else begin
                                    state <= DATA_WR;
                                end
                            end
                        end
                    end
                    DATA_RD: begin
                        // Zero fill makes MISO idle low once all 16 bits are out.
                        if (fall) begin
                            spi.spi_miso <= shreg[0];
                            shreg        <= {1'b0, shreg[15:1]};
                        end
                    end
                    DATA_WR: begin
                        spi.spi_miso <= 1'b0;
                        if (rise)
                            wbuf <= wdata_next[15:1];
                    end
                    default: begin
                        spi.spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_word_target.sv
// Bench for spi_word_target: a read/write DUT and a READ_ONLY DUT share one SPI
// stimulus and backdoor bus, and are checked against word-array reference models.
module tb_spi_word_target;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cs_n = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [15:0]   load_data = '0;
    logic          busy0, busy1, err0, err1;

    spi_word_target_if sif0 ();
    spi_word_target_if sif1 ();

    assign sif0.spi_cs_n = cs_n;
    assign sif0.spi_clk  = sclk;
    assign sif0.spi_mosi = mosi;
    assign sif1.spi_cs_n = cs_n;
    assign sif1.spi_clk  = sclk;
    assign sif1.spi_mosi = mosi;

    spi_word_target #(.AW(AW), .READ_ONLY(1'b0)) dut_rw (
        .clk(clk), .rst(rst), .spi(sif0.slave),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy0), .cmd_err(err0));

    spi_word_target #(.AW(AW), .READ_ONLY(1'b1)) dut_ro (
        .clk(clk), .rst(rst), .spi(sif1.slave),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy1), .cmd_err(err1));

    int checks = 0;
    int errors = 0;
    int err_cnt0 = 0;
    int err_cnt1 = 0;

    logic [15:0] m_rw [256];
    logic [15:0] m_ro [256];

    // Every clk cycle cmd_err is high is counted, so pulse width is checked too.
    always @(negedge clk) begin
        if (err0 === 1'b1) err_cnt0++;
        if (err1 === 1'b1) err_cnt1++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        m_rw[a] = d;
        m_ro[a] = d;
    endtask

    // One SPI bit, 2 clk per level. MISO is sampled one clk after the fall is seen.
    task automatic xfer_bit(input logic b, input logic ld, input logic [AW-1:0] la,
                            input logic [15:0] ldd, output logic r0, output logic r1,
                            output logic bz0, output logic bz1);
        @(negedge clk);
        sclk = 1'b0; mosi = b;
        @(negedge clk);
        r0 = sif0.spi_miso; r1 = sif1.spi_miso; bz0 = busy0; bz1 = busy1;
        @(negedge clk);
        sclk = 1'b1;
        if (ld) begin
            load_en = 1'b1; load_addr = la; load_data = ldd;
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic spi_txn(input logic [7:0] c, input logic [15:0] a, input logic [15:0] d,
                           input int nbits, input bit coll, input logic [AW-1:0] ca,
                           input logic [15:0] cd, input bit do_rst);
        logic [39:0] frame;
        logic [15:0] rv0, rv1, got0, got1;
        logic        r0, r1, bz0, bz1, x0, x1;
        int          e0, e1;
        bit          is_rd, bad, wr_ok, coll_eff;
        for (int i = 0; i < 8; i++)  frame[i] = c[7-i];
        for (int j = 0; j < 16; j++) frame[8+j] = a[j];
        for (int j = 0; j < 16; j++) frame[24+j] = d[j];
        rv0 = m_rw[a[AW-1:0]];
        rv1 = m_ro[a[AW-1:0]];
        got0 = '0; got1 = '0;
        is_rd    = (c == 8'h03);
        bad      = (c != 8'h02) && (c != 8'h03) && (nbits >= 8) && !do_rst;
        wr_ok    = (c == 8'h02) && (nbits == 40) && !do_rst;
        coll_eff = coll && (nbits == 40);
        e0 = err_cnt0; e1 = err_cnt1;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            xfer_bit(frame[i], coll_eff && (i == 39), ca, cd, r0, r1, bz0, bz1);
            x0 = (is_rd && i >= 24) ? rv0[i-24] : 1'b0;
            x1 = (is_rd && i >= 24) ? rv1[i-24] : 1'b0;
            check("miso_rw", 16'(r0), 16'(x0));
            check("miso_ro", 16'(r1), 16'(x1));
            if (i >= 24) begin
                got0[i-24] = r0;
                got1[i-24] = r1;
            end
            if (i > 0) begin
                check("busy_rw", 16'(bz0), 16'd1);
                check("busy_ro", 16'(bz1), 16'd1);
            end
        end
        if (is_rd && nbits == 40) begin
            check("rd_word_rw", got0, rv0);
            check("rd_word_ro", got1, rv1);
        end
        if (do_rst) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("rst_miso_rw", 16'(sif0.spi_miso), 16'd0);
            check("rst_miso_ro", 16'(sif1.spi_miso), 16'd0);
            check("rst_busy_rw", 16'(busy0), 16'd0);
            check("rst_busy_ro", 16'(busy1), 16'd0);
            rst  = 1'b0;
            cs_n = 1'b1;
        end
        @(negedge clk);
        sclk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_busy_rw", 16'(busy0), 16'd0);
        check("idle_busy_ro", 16'(busy1), 16'd0);
        check("idle_miso_rw", 16'(sif0.spi_miso), 16'd0);
        check("idle_miso_ro", 16'(sif1.spi_miso), 16'd0);
        check("cmd_err_rw", 16'(err_cnt0 - e0), 16'(bad));
        check("cmd_err_ro", 16'(err_cnt1 - e1), 16'(bad));
        if (wr_ok)
            m_rw[a[AW-1:0]] = d;
        else if (coll_eff)
            m_rw[ca] = cd;
        if (coll_eff)
            m_ro[ca] = cd;
    endtask

    task automatic rd(input logic [15:0] a);
        spi_txn(8'h03, a, 16'h0000, 40, 1'b0, '0, 16'h0, 1'b0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("reset_miso_rw", 16'(sif0.spi_miso), 16'd0);
        check("reset_miso_ro", 16'(sif1.spi_miso), 16'd0);
        check("reset_busy_rw", 16'(busy0), 16'd0);
        check("reset_busy_ro", 16'(busy1), 16'd0);
        check("reset_err_rw", 16'(err0), 16'd0);
        check("reset_err_ro", 16'(err1), 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) load_word(AW'(i), 16'($urandom));
        load_word(8'h05, 16'hA5C3);
        load_word(8'h12, 16'h1234);

        rd(16'h0005);
        spi_txn(8'h02, 16'h0012, 16'h8001, 32, 1'b0, '0, 16'h0, 1'b0);
        rd(16'h0012);
        spi_txn(8'h02, 16'h0012, 16'h8001, 40, 1'b0, '0, 16'h0, 1'b0);
        rd(16'h0012);
        spi_txn(8'h0B, 16'h0012, 16'hFFFF, 40, 1'b0, '0, 16'h0, 1'b0);
        rd(16'h0012);
        rd(16'h8105);
        spi_txn(8'h02, 16'h0012, 16'hBEEF, 40, 1'b1, 8'h12, 16'h5555, 1'b0);
        rd(16'h0012);
        spi_txn(8'h02, 16'h0020, 16'h1357, 40, 1'b1, 8'h07, 16'h9999, 1'b0);
        rd(16'h0007);
        rd(16'h0020);
        spi_txn(8'h02, 16'h0005, 16'hFFFF, 30, 1'b0, '0, 16'h0, 1'b1);
        rd(16'h0005);
        spi_txn(8'h02, 16'h0005, 16'hFFFF, 5, 1'b0, '0, 16'h0, 1'b0);
        rd(16'h0005);

        for (int n = 0; n < 30; n++) begin
            logic [7:0]  c;
            logic [15:0] a, d, cd;
            logic [AW-1:0] ca;
            int          nb, sel;
            bit          coll;
            if ($urandom_range(0, 2) == 0)
                load_word(AW'($urandom), 16'($urandom));
            sel = int'($urandom_range(0, 3));
            c  = (sel < 2) ? 8'h03 : (sel == 2) ? 8'h02 : 8'($urandom);
            a  = 16'($urandom_range(0, 15)) | (16'($urandom) & 16'hFF00);
            d  = 16'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 40;
            coll = ($urandom_range(0, 3) == 0);
            ca = AW'($urandom_range(0, 15));
            cd = 16'($urandom);
            spi_txn(c, a, d, nb, coll, ca, cd, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
